// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
// Owns the fetch PC, issues word-aligned requests to instruction memory over a
// req/ack handshake, and presents fetched words to decode through a one-entry
// valid/ready output register. Redirects (PCsrc) flush the output register and
// discard any in-flight fetch.
// Optional feature macro: FETCH_PERF_EN enables the perf_fetches and
// perf_redirects counters; when undefined both ports are tied to zero.
//
// Handshakes:
//   imem side : imem_req is held high with imem_addr stable until a cycle in
//               which imem_ack=1; that rising edge completes the request and
//               imem_rdata is taken in that same cycle. imem_ack is ignored
//               while imem_req=0.
//   decode side: an instruction transfers on a rising edge where
//               if_valid=1 and if_ready=1 (and no redirect is strobing);
//               if_pc/if_instr stay stable while if_valid=1 and not taken.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCsrc,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_redirects,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] target_q, target_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] redir_tgt;
  logic        ack_v;
  logic        take;
  logic        slot_free;

  // Redirect targets are always word aligned.
  assign redir_tgt = redirect_pc & ~32'd3;
  // An ack only counts while a request is actually outstanding.
  assign ack_v     = imem_ack & req_q;
  // Decode takes the presented word; a redirect in the same cycle vetoes it.
  assign take      = valid_q & if_ready & ~PCsrc;
  // The output register can accept a new word at this edge.
  assign slot_free = ~valid_q | take;

  // Next-state, request and output-register logic.
  // A non-redirect ack that arrives while the output register is full and not
  // draining cannot be stored, so its data is dropped, the PC is not advanced
  // and the controller waits in HOLD; the same address is refetched once the
  // held word is taken. This keeps every presented word in program order.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    target_d = target_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        if (PCsrc) begin
          addr_d = redir_tgt;
        end
      end
      S_FETCH: begin
        if (PCsrc) begin
          valid_d = 1'b0;
          if (ack_v) begin
            addr_d = redir_tgt;
          end else begin
            state_d  = S_DRAIN;
            target_d = redir_tgt;
          end
        end else if (ack_v) begin
          if (slot_free) begin
            valid_d = 1'b1;
            pc_d    = addr_q;
            instr_d = imem_rdata;
            addr_d  = addr_q + 32'd4;
          end else begin
            state_d = S_HOLD;
            req_d   = 1'b0;
          end
        end else if (take) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (PCsrc) begin
          valid_d = 1'b0;
          addr_d  = redir_tgt;
          state_d = S_FETCH;
          req_d   = 1'b1;
        end else if (take) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (ack_v) begin
          state_d = S_FETCH;
          addr_d  = PCsrc ? redir_tgt : target_q;
        end else if (PCsrc) begin
          target_d = redir_tgt;
        end
      end
      default: begin
        state_d = S_BOOT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      target_q <= 32'd0;
      valid_q  <= 1'b0;
      pc_q     <= 32'd0;
      instr_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_pc     = pc_q;
  assign if_instr  = instr_q;
  assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_redir_q, perf_redir_d;
  logic        fetch_hit;
  logic        redir_hit;

  // Stored fetches are the FETCH-state acks that land in the output register.
  assign fetch_hit = (state_q == S_FETCH) & ack_v & ~PCsrc & slot_free;
  assign redir_hit = PCsrc & (state_q != S_BOOT);

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, fetch_hit};
    perf_redir_d = perf_redir_q + {31'd0, redir_hit};
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 32'd0;
      perf_redir_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_fetches   = perf_fetch_q;
  assign perf_redirects = perf_redir_q;
`else
  assign perf_fetches   = 32'd0;
  assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with an abstract reference model
// and a per-cycle compare process, plus hand-computed literal checkpoints.
module tb_fetch_ctrl;

  localparam logic [31:0] K = 32'h5A5A_0000;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_ack = 1'b0;
  logic        if_ready = 1'b0;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_instr, perf_fetches, perf_redirects;
  logic [1:0]  dbg_state;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr, w_pf, w_pr;
  logic [1:0]  w_dbg;

  always #5 clk = ~clk;

  // Memory returns a word derived from its address.
  assign imem_rdata = imem_addr ^ K;
  assign w_rdata    = w_addr ^ K;

  fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .perf_fetches(perf_fetches),
    .perf_redirects(perf_redirects), .dbg_state(dbg_state)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
    .imem_rdata(w_rdata), .if_valid(w_valid), .if_ready(if_ready),
    .if_pc(w_pc), .if_instr(w_instr), .perf_fetches(w_pf),
    .perf_redirects(w_pr), .dbg_state(w_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: is a request outstanding, at which address, will its data
  // be thrown away, and what does the one-slot output buffer hold.
  logic        m_started, m_req, m_stale, m_sv;
  logic [31:0] m_addr, m_tgt, m_spc, m_sinstr, m_nf, m_nr;

  task automatic model_reset();
    m_started = 1'b0; m_req = 1'b0; m_stale = 1'b0; m_sv = 1'b0;
    m_addr = 32'd0; m_tgt = 32'd0; m_spc = 32'd0; m_sinstr = 32'd0;
    m_nf = 32'd0; m_nr = 32'd0;
  endtask

  task automatic model_edge(input logic ack, input logic rdy, input logic pcs,
                            input logic [31:0] tgt);
    logic acc;
    if (!m_started) begin
      m_started = 1'b1;
      m_req = 1'b1;
      if (pcs) m_addr = tgt & ~32'd3;
    end else begin
      acc = m_sv && rdy && !pcs;
      if (pcs) begin
        m_nr = m_nr + 1;
        m_sv = 1'b0;
        if (m_req && !ack) begin
          m_stale = 1'b1;
          m_tgt = tgt & ~32'd3;
        end else begin
          m_addr = tgt & ~32'd3;
          m_req = 1'b1;
          m_stale = 1'b0;
        end
      end else if (m_req && ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
          m_addr = m_tgt;
        end else if (!m_sv || acc) begin
          m_sv = 1'b1;
          m_spc = m_addr;
          m_sinstr = m_addr ^ K;
          m_nf = m_nf + 1;
          m_addr = m_addr + 32'd4;
        end else begin
          m_req = 1'b0;
        end
      end else if (acc) begin
        m_sv = 1'b0;
        m_req = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_req",   {31'd0, imem_req}, {31'd0, m_req});
      chk("cmp_addr",  imem_addr, m_addr);
      chk("cmp_valid", {31'd0, if_valid}, {31'd0, m_sv});
      if (m_sv) begin
        chk("cmp_pc",    if_pc, m_spc);
        chk("cmp_instr", if_instr, m_sinstr);
      end
      chk("cmp_perf_f", perf_fetches, PERF ? m_nf : 32'd0);
      chk("cmp_perf_r", perf_redirects, PERF ? m_nr : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic ack, input logic rdy, input logic pcs,
                      input logic [31:0] tgt);
    imem_ack = ack; if_ready = rdy; PCsrc = pcs; redirect_pc = tgt;
    @(posedge clk);
    model_edge(ack, rdy, pcs, tgt);
    #1;
  endtask

  task automatic do_reset();
    imem_ack = 1'b0; if_ready = 1'b0; PCsrc = 1'b0; redirect_pc = 32'd0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   imem_addr, 32'd0);
    chk("rst_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_pc",     if_pc, 32'd0);
    chk("rst_instr",  if_instr, 32'd0);
    chk("rst_perf_f", perf_fetches, 32'd0);
    chk("rst_perf_r", perf_redirects, 32'd0);
    chk("rst_state",  {30'd0, dbg_state}, 32'd0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_w_req",  {31'd0, w_req}, 32'd0);

    // A: zero-wait streaming; wrap instance checks RESET_PC wraparound.
    do_reset();
    #1;
    chk("a_boot_req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("a_first_req",  {31'd0, imem_req}, 32'd1);
    chk("a_first_addr", imem_addr, 32'h0);
    chk("e_first_addr", w_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("a_v0",     {31'd0, if_valid}, 32'd1);
    chk("a_pc0",    if_pc, 32'h0);
    chk("a_instr0", if_instr, 32'h5A5A_0000);
    chk("a_addr4",  imem_addr, 32'h4);
    chk("e_addr0",  w_addr, 32'h0);
    chk("e_pc",     w_pc, 32'hFFFF_FFFC);
    chk("e_instr",  w_instr, 32'hA5A5_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("a_pc4",   if_pc, 32'h4);
    chk("a_addr8", imem_addr, 32'h8);
    chk("e_addr4", w_addr, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("a_pc8",   if_pc, 32'h8);
    chk("a_v8",    {31'd0, if_valid}, 32'd1);
    chk("a_addrc", imem_addr, 32'hC);

    // B: decode stalls for three cycles after the first instruction.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("b_pc0",   if_pc, 32'h0);
    chk("b_addr4", imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("b_hold_req",  {31'd0, imem_req}, 32'd0);
    chk("b_hold_pc",   if_pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("b_hold2_pc",  if_pc, 32'h0);
    chk("b_hold2_req", {31'd0, imem_req}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("b_resume_req",  {31'd0, imem_req}, 32'd1);
    chk("b_resume_addr", imem_addr, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("b_pc4",   if_pc, 32'h4);
    chk("b_addr8", imem_addr, 32'h8);

    // C: redirect while the request to 0x8 waits for its ack.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h103);
    chk("c_drain_addr",  imem_addr, 32'h8);
    chk("c_drain_req",   {31'd0, imem_req}, 32'd1);
    chk("c_drain_valid", {31'd0, if_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("c_drain_addr2", imem_addr, 32'h8);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("c_tgt_addr", imem_addr, 32'h100);
    chk("c_dropped",  {31'd0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("c_pc100",    if_pc, 32'h100);
    chk("c_instr100", if_instr, 32'h5A5A_0100);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("c_pc108", if_pc, 32'h108);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("c_perf_f", perf_fetches, PERF ? 32'd5 : 32'd0);
    chk("c_perf_r", perf_redirects, PERF ? 32'd1 : 32'd0);

    // D: redirect in the same cycle as an ack.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h202);
    chk("d_valid", {31'd0, if_valid}, 32'd0);
    chk("d_addr",  imem_addr, 32'h200);
    chk("d_req",   {31'd0, imem_req}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("d_pc",    if_pc, 32'h200);
    chk("d_instr", if_instr, 32'h5A5A_0200);

    // F: reset dropped while a request is outstanding.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("f_pending_addr", imem_addr, 32'h8);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("f_req_now",   {31'd0, imem_req}, 32'd0);
    chk("f_addr_now",  imem_addr, 32'h0);
    chk("f_valid_now", {31'd0, if_valid}, 32'd0);
    chk("f_perf_now",  perf_fetches, 32'd0);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("f_refetch_req",  {31'd0, imem_req}, 32'd1);
    chk("f_refetch_addr", imem_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("f_refetch_pc", if_pc, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
